// File: rtl/rtc_bus_signal_gen_if.sv
// Signal bundle between the RTC bus-timing counter side and rtc_bus_signal_gen.
// The master modport drives phase, requests and pad input; the slave modport is the decoder.
interface rtc_bus_signal_gen_if #(
   parameter int DATA_W = 8
);
   logic [3:0]        c_5;
   logic              enable_inicio;
   logic              enable_escribir;
   logic              enable_leer;
   logic [DATA_W-1:0] direccion;
   logic [DATA_W-1:0] dato_escribir;
   logic [DATA_W-1:0] bus_in;
   logic [DATA_W-1:0] bus_out;
   logic              bus_oe;
   logic              cs_n;
   logic              rd_n;
   logic              wr_n;
   logic              ad;
   logic [DATA_W-1:0] dato_leido;
   logic              dato_valido;
   logic              listo;
   logic              ocupado;
   logic              error_bus;

   modport master (
      output c_5, enable_inicio, enable_escribir, enable_leer,
             direccion, dato_escribir, bus_in,
      input  bus_out, bus_oe, cs_n, rd_n, wr_n, ad,
             dato_leido, dato_valido, listo, ocupado, error_bus
   );

   modport slave (
      input  c_5, enable_inicio, enable_escribir, enable_leer,
             direccion, dato_escribir, bus_in,
      output bus_out, bus_oe, cs_n, rd_n, wr_n, ad,
             dato_leido, dato_valido, listo, ocupado, error_bus
   );
endinterface

// File: rtl/rtc_bus_signal_gen.sv
// Decodes the timing-counter phase c_5 into registered RTC parallel-bus strobes,
// drives address/data, captures read data. Optional feature macro: RTC_WRITE_VERIFY_EN.
module rtc_bus_signal_gen #(
   parameter int DATA_W       = 8,
   parameter int SAMPLE_PHASE = 6,
   parameter int LAST_PHASE   = 11
) (
   input logic                 clk,
   input logic                 reset,
   rtc_bus_signal_gen_if.slave bus_if
);

   localparam logic [3:0] SAMPLE_PH   = 4'(SAMPLE_PHASE);
   localparam logic [3:0] SAMPLE_NEXT = 4'(SAMPLE_PHASE + 1);
   localparam logic [3:0] LAST_PH     = 4'(LAST_PHASE);

   typedef enum logic {
      MODE_READ  = 1'b0,
      MODE_WRITE = 1'b1
   } mode_t;

   mode_t             mode;
   logic [3:0]        c_prev;
   logic [DATA_W-1:0] bus_in_q;
   logic [3:0]        phase;
   logic              sample_edge;
   logic              done_edge;

   logic              cs_n_d;
   logic              rd_n_d;
   logic              wr_n_d;
   logic              ad_d;
   logic              oe_d;
   logic [DATA_W-1:0] out_d;

   logic              cs_n_q;
   logic              rd_n_q;
   logic              wr_n_q;
   logic              ad_q;
   logic              oe_q;
   logic [DATA_W-1:0] out_q;
   logic [DATA_W-1:0] leido_q;
   logic              valido_q;
   logic              listo_q;

   assign phase       = (bus_if.c_5 > LAST_PH) ? 4'd0 : bus_if.c_5;
   assign sample_edge = (c_prev == SAMPLE_PH) && (bus_if.c_5 == SAMPLE_NEXT);
   assign done_edge   = (c_prev == LAST_PH) && (bus_if.c_5 == 4'd0);

   // Next strobe/bus values for the phase currently on c_5; registered below.
   always_comb begin
      cs_n_d = 1'b1;
      rd_n_d = 1'b1;
      wr_n_d = 1'b1;
      ad_d   = 1'b1;
      oe_d   = 1'b0;
      out_d  = '0;
      case (phase)
         4'd1: begin
            ad_d  = 1'b0;
            oe_d  = 1'b1;
            out_d = bus_if.direccion;
         end
         4'd2, 4'd4: begin
            ad_d   = 1'b0;
            cs_n_d = 1'b0;
            oe_d   = 1'b1;
            out_d  = bus_if.direccion;
         end
         4'd3: begin
            ad_d   = 1'b0;
            cs_n_d = 1'b0;
            wr_n_d = 1'b0;
            oe_d   = 1'b1;
            out_d  = bus_if.direccion;
         end
         4'd6: begin
            cs_n_d = 1'b0;
            if (mode == MODE_WRITE) begin
               wr_n_d = 1'b0;
               oe_d   = 1'b1;
               out_d  = bus_if.dato_escribir;
            end else begin
               rd_n_d = 1'b0;
            end
         end
         4'd7: begin
            cs_n_d = 1'b0;
            if (mode == MODE_WRITE) begin
               oe_d  = 1'b1;
               out_d = bus_if.dato_escribir;
            end
         end
         default: begin
            cs_n_d = 1'b1;
         end
      endcase
   end

   // Mode is only sampled while idle so a transaction keeps its direction to the end.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mode     <= MODE_WRITE;
         c_prev   <= 4'd0;
         bus_in_q <= '0;
         cs_n_q   <= 1'b1;
         rd_n_q   <= 1'b1;
         wr_n_q   <= 1'b1;
         ad_q     <= 1'b1;
         oe_q     <= 1'b0;
         out_q    <= '0;
         leido_q  <= '0;
         valido_q <= 1'b0;
         listo_q  <= 1'b0;
      end else begin
         c_prev   <= bus_if.c_5;
         bus_in_q <= bus_if.bus_in;
         if (bus_if.c_5 == 4'd0) begin
            if (bus_if.enable_escribir || bus_if.enable_inicio) begin
               mode <= MODE_WRITE;
            end else if (bus_if.enable_leer) begin
               mode <= MODE_READ;
            end
         end
         cs_n_q   <= cs_n_d;
         rd_n_q   <= rd_n_d;
         wr_n_q   <= wr_n_d;
         ad_q     <= ad_d;
         oe_q     <= oe_d;
         out_q    <= out_d;
         valido_q <= sample_edge && (mode == MODE_READ);
         if (sample_edge && (mode == MODE_READ)) begin
            leido_q <= bus_in_q;
         end
         listo_q  <= done_edge;
      end
   end

`ifdef RTC_WRITE_VERIFY_EN
   logic error_q;

   // Loopback of our own write data; any mismatch latches until reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         error_q <= 1'b0;
      end else if (sample_edge && (mode == MODE_WRITE) &&
                   (bus_in_q != bus_if.dato_escribir)) begin
         error_q <= 1'b1;
      end
   end

   assign bus_if.error_bus = error_q;
`else
   assign bus_if.error_bus = 1'b0;
`endif

   assign bus_if.cs_n        = cs_n_q;
   assign bus_if.rd_n        = rd_n_q;
   assign bus_if.wr_n        = wr_n_q;
   assign bus_if.ad          = ad_q;
   assign bus_if.bus_oe      = oe_q;
   assign bus_if.bus_out     = out_q;
   assign bus_if.dato_leido  = leido_q;
   assign bus_if.dato_valido = valido_q;
   assign bus_if.listo       = listo_q;
   assign bus_if.ocupado     = (bus_if.c_5 != 4'd0) | bus_if.enable_inicio |
                               bus_if.enable_escribir | bus_if.enable_leer;

endmodule

// File: tb/tb_rtc_bus_signal_gen.sv
// Directed bench for rtc_bus_signal_gen: table-driven write/read sequences plus
// hand-written conflict, abort, phase-jump, async-reset and write-verify cases.
module tb_rtc_bus_signal_gen;

`ifdef RTC_WRITE_VERIFY_EN
   localparam logic VERIFY_EN = 1'b1;
`else
   localparam logic VERIFY_EN = 1'b0;
`endif

   typedef struct {
      logic [3:0] c5;
      logic       esc;
      logic       leer;
      logic [7:0] dir;
      logic [7:0] bin;
      logic       cs_n;
      logic       rd_n;
      logic       wr_n;
      logic       ad;
      logic       oe;
      logic [7:0] out;
      logic       listo;
      logic       valido;
      logic [7:0] leido;
   } vec_t;

   logic clk;
   logic reset;
   int   checks;
   int   errors;
   vec_t vecs[$];

   rtc_bus_signal_gen_if #(.DATA_W(8)) bus_if ();

   rtc_bus_signal_gen dut (
      .clk    (clk),
      .reset  (reset),
      .bus_if (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%02h expected 0x%02h at %0t", name, act, exp, $time);
      end
   endtask

   // Drives one phase value for one full cycle; returns at the negedge after the
   // active edge so the registered outputs reflect that phase.
   task automatic applyStimulus(input logic [3:0] c5, input logic esc, input logic leer,
                                input logic ini, input logic [7:0] bin);
      @(negedge clk);
      bus_if.c_5             = c5;
      bus_if.enable_escribir = esc;
      bus_if.enable_leer     = leer;
      bus_if.enable_inicio   = ini;
      bus_if.bus_in          = bin;
      @(negedge clk);
   endtask

   task automatic checkStrobes(input string tag, input logic cs, input logic rd,
                               input logic wr, input logic ad, input logic oe);
      checkOutput({tag, ".cs_n"}, 8'(bus_if.cs_n), 8'(cs));
      checkOutput({tag, ".rd_n"}, 8'(bus_if.rd_n), 8'(rd));
      checkOutput({tag, ".wr_n"}, 8'(bus_if.wr_n), 8'(wr));
      checkOutput({tag, ".ad"}, 8'(bus_if.ad), 8'(ad));
      checkOutput({tag, ".bus_oe"}, 8'(bus_if.bus_oe), 8'(oe));
   endtask

   function automatic void add_vec(input logic [3:0] c5, input logic esc, input logic leer,
                                   input logic [7:0] dir, input logic [7:0] bin,
                                   input logic cs, input logic rd, input logic wr,
                                   input logic ad, input logic oe, input logic [7:0] out,
                                   input logic listo, input logic valido,
                                   input logic [7:0] leido);
      vec_t v;
      v.c5 = c5; v.esc = esc; v.leer = leer; v.dir = dir; v.bin = bin;
      v.cs_n = cs; v.rd_n = rd; v.wr_n = wr; v.ad = ad; v.oe = oe; v.out = out;
      v.listo = listo; v.valido = valido; v.leido = leido;
      vecs.push_back(v);
   endfunction

   initial begin
      checks = 0;
      errors = 0;
      reset  = 1'b1;
      bus_if.c_5             = 4'd0;
      bus_if.enable_inicio   = 1'b0;
      bus_if.enable_escribir = 1'b0;
      bus_if.enable_leer     = 1'b0;
      bus_if.direccion       = 8'h00;
      bus_if.dato_escribir   = 8'h5A;
      bus_if.bus_in          = 8'h00;

      // Write 0x5A to 0x21; loopback data matches so verify stays clean.
      add_vec(4'd0, 1, 0, 8'h21, 8'h00, 1, 1, 1, 1, 0, 8'h00, 0, 0, 8'h00);
      add_vec(4'd1, 1, 0, 8'h21, 8'h00, 1, 1, 1, 0, 1, 8'h21, 0, 0, 8'h00);
      add_vec(4'd2, 1, 0, 8'h21, 8'h00, 0, 1, 1, 0, 1, 8'h21, 0, 0, 8'h00);
      add_vec(4'd3, 1, 0, 8'h21, 8'h00, 0, 1, 0, 0, 1, 8'h21, 0, 0, 8'h00);
      add_vec(4'd4, 1, 0, 8'h21, 8'h00, 0, 1, 1, 0, 1, 8'h21, 0, 0, 8'h00);
      add_vec(4'd5, 1, 0, 8'h21, 8'h00, 1, 1, 1, 1, 0, 8'h00, 0, 0, 8'h00);
      add_vec(4'd6, 1, 0, 8'h21, 8'h5A, 0, 1, 0, 1, 1, 8'h5A, 0, 0, 8'h00);
      add_vec(4'd7, 1, 0, 8'h21, 8'h00, 0, 1, 1, 1, 1, 8'h5A, 0, 0, 8'h00);
      for (int p = 8; p <= 11; p++)
         add_vec(4'(p), 1, 0, 8'h21, 8'h00, 1, 1, 1, 1, 0, 8'h00, 0, 0, 8'h00);
      add_vec(4'd0, 0, 0, 8'h21, 8'h00, 1, 1, 1, 1, 0, 8'h00, 1, 0, 8'h00);
      add_vec(4'd0, 0, 0, 8'h21, 8'h00, 1, 1, 1, 1, 0, 8'h00, 0, 0, 8'h00);
      // Read from 0x33 with the RTC returning 0xC4 during phase 6.
      add_vec(4'd0, 0, 1, 8'h33, 8'h00, 1, 1, 1, 1, 0, 8'h00, 0, 0, 8'h00);
      add_vec(4'd1, 0, 1, 8'h33, 8'h00, 1, 1, 1, 0, 1, 8'h33, 0, 0, 8'h00);
      add_vec(4'd2, 0, 1, 8'h33, 8'h00, 0, 1, 1, 0, 1, 8'h33, 0, 0, 8'h00);
      add_vec(4'd3, 0, 1, 8'h33, 8'h00, 0, 1, 0, 0, 1, 8'h33, 0, 0, 8'h00);
      add_vec(4'd4, 0, 1, 8'h33, 8'h00, 0, 1, 1, 0, 1, 8'h33, 0, 0, 8'h00);
      add_vec(4'd5, 0, 1, 8'h33, 8'h00, 1, 1, 1, 1, 0, 8'h00, 0, 0, 8'h00);
      add_vec(4'd6, 0, 1, 8'h33, 8'hC4, 0, 0, 1, 1, 0, 8'h00, 0, 0, 8'h00);
      add_vec(4'd7, 0, 1, 8'h33, 8'h00, 0, 1, 1, 1, 0, 8'h00, 0, 1, 8'hC4);
      for (int p = 8; p <= 11; p++)
         add_vec(4'(p), 0, 1, 8'h33, 8'h00, 1, 1, 1, 1, 0, 8'h00, 0, 0, 8'hC4);
      add_vec(4'd0, 0, 0, 8'h33, 8'h00, 1, 1, 1, 1, 0, 8'h00, 1, 0, 8'hC4);
      add_vec(4'd0, 0, 0, 8'h33, 8'h00, 1, 1, 1, 1, 0, 8'h00, 0, 0, 8'hC4);

      repeat (2) @(negedge clk);
      checkStrobes("reset", 1, 1, 1, 1, 0);
      checkOutput("reset.bus_out", bus_if.bus_out, 8'h00);
      checkOutput("reset.dato_leido", bus_if.dato_leido, 8'h00);
      checkOutput("reset.pulses", {6'd0, bus_if.listo, bus_if.dato_valido}, 8'h00);
      checkOutput("reset.error_bus", 8'(bus_if.error_bus), 8'h00);
      reset = 1'b0;

      foreach (vecs[i]) begin
         bus_if.direccion = vecs[i].dir;
         applyStimulus(vecs[i].c5, vecs[i].esc, vecs[i].leer, 1'b0, vecs[i].bin);
         checkStrobes($sformatf("v%0d", i), vecs[i].cs_n, vecs[i].rd_n, vecs[i].wr_n,
                      vecs[i].ad, vecs[i].oe);
         if (vecs[i].oe)
            checkOutput($sformatf("v%0d.bus_out", i), bus_if.bus_out, vecs[i].out);
         checkOutput($sformatf("v%0d.listo", i), 8'(bus_if.listo), 8'(vecs[i].listo));
         checkOutput($sformatf("v%0d.dato_valido", i), 8'(bus_if.dato_valido), 8'(vecs[i].valido));
         checkOutput($sformatf("v%0d.dato_leido", i), bus_if.dato_leido, vecs[i].leido);
         checkOutput($sformatf("v%0d.ocupado", i), 8'(bus_if.ocupado),
                     8'((vecs[i].c5 != 4'd0) | vecs[i].esc | vecs[i].leer));
      end
      checkOutput("tbl.error_bus", 8'(bus_if.error_bus), 8'h00);

      // Simultaneous read and write requests: write wins, nothing captured.
      bus_if.direccion = 8'h44;
      for (int p = 0; p <= 5; p++) applyStimulus(4'(p), 1, 1, 0, 8'h00);
      applyStimulus(4'd6, 1, 1, 0, 8'h5A);
      checkStrobes("both.ph6", 0, 1, 0, 1, 1);
      applyStimulus(4'd7, 1, 1, 0, 8'h00);
      checkOutput("both.dato_valido", 8'(bus_if.dato_valido), 8'h00);
      checkOutput("both.dato_leido", bus_if.dato_leido, 8'hC4);
      for (int p = 8; p <= 11; p++) applyStimulus(4'(p), 0, 0, 0, 8'h00);
      applyStimulus(4'd0, 0, 0, 0, 8'h00);
      checkOutput("both.listo", 8'(bus_if.listo), 8'h01);

      // Read aborted in phase 6: counter forced back to 0.
      bus_if.direccion = 8'h10;
      for (int p = 0; p <= 5; p++) applyStimulus(4'(p), 0, 1, 0, 8'h00);
      applyStimulus(4'd6, 0, 1, 0, 8'h99);
      checkOutput("abort.ph6.rd_n", 8'(bus_if.rd_n), 8'h00);
      applyStimulus(4'd0, 0, 0, 0, 8'h00);
      checkStrobes("abort", 1, 1, 1, 1, 0);
      checkOutput("abort.listo", 8'(bus_if.listo), 8'h00);
      checkOutput("abort.dato_valido", 8'(bus_if.dato_valido), 8'h00);
      checkOutput("abort.dato_leido", bus_if.dato_leido, 8'hC4);
      applyStimulus(4'd0, 0, 0, 0, 8'h00);
      checkOutput("abort.listo2", 8'(bus_if.listo), 8'h00);

      // Phase jumps and out-of-range phase decode.
      applyStimulus(4'd0, 0, 1, 0, 8'h00);
      applyStimulus(4'd2, 0, 1, 0, 8'h00);
      checkStrobes("jump.ph2", 0, 1, 1, 0, 1);
      applyStimulus(4'd13, 0, 1, 0, 8'h00);
      checkStrobes("jump.ph13", 1, 1, 1, 1, 0);
      applyStimulus(4'd7, 0, 1, 0, 8'h77);
      checkStrobes("jump.ph7", 0, 1, 1, 1, 0);
      checkOutput("jump.dato_valido", 8'(bus_if.dato_valido), 8'h00);
      applyStimulus(4'd0, 0, 0, 0, 8'h00);
      checkOutput("jump.listo", 8'(bus_if.listo), 8'h00);
      checkOutput("jump.dato_leido", bus_if.dato_leido, 8'hC4);

      // Async reset in the middle of phase 3 of an init write.
      bus_if.direccion = 8'h21;
      for (int p = 0; p <= 3; p++) applyStimulus(4'(p), 0, 0, 1, 8'h00);
      checkOutput("rst.pre.wr_n", 8'(bus_if.wr_n), 8'h00);
      #1 reset = 1'b1;
      #1;
      checkStrobes("rst.async", 1, 1, 1, 1, 0);
      checkOutput("rst.bus_out", bus_if.bus_out, 8'h00);
      checkOutput("rst.dato_leido", bus_if.dato_leido, 8'h00);
      checkOutput("rst.pulses", {6'd0, bus_if.listo, bus_if.dato_valido}, 8'h00);
      #1 reset = 1'b0;
      bus_if.c_5 = 4'd0;
      bus_if.enable_inicio = 1'b0;
      applyStimulus(4'd0, 0, 0, 0, 8'h00);
      checkStrobes("rst.after", 1, 1, 1, 1, 0);

      // Write whose loopback data disagrees, then a clean write: error stays set.
      for (int p = 0; p <= 5; p++) applyStimulus(4'(p), 1, 0, 0, 8'h00);
      applyStimulus(4'd6, 1, 0, 0, 8'h5B);
      applyStimulus(4'd7, 1, 0, 0, 8'h00);
      checkOutput("verify.error_bus", 8'(bus_if.error_bus), 8'(VERIFY_EN));
      for (int p = 8; p <= 11; p++) applyStimulus(4'(p), 1, 0, 0, 8'h00);
      applyStimulus(4'd0, 0, 0, 0, 8'h00);
      checkOutput("verify.listo", 8'(bus_if.listo), 8'h01);
      for (int p = 0; p <= 5; p++) applyStimulus(4'(p), 1, 0, 0, 8'h00);
      applyStimulus(4'd6, 1, 0, 0, 8'h5A);
      for (int p = 7; p <= 11; p++) applyStimulus(4'(p), 1, 0, 0, 8'h00);
      applyStimulus(4'd0, 0, 0, 0, 8'h00);
      checkOutput("verify.sticky", 8'(bus_if.error_bus), 8'(VERIFY_EN));
      #1 reset = 1'b1;
      #1;
      checkOutput("verify.cleared", 8'(bus_if.error_bus), 8'h00);
      #1 reset = 1'b0;
      repeat (2) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
